// File: rtl/fluxo_dados_multiciclo_if.sv
// Fetch-side handshake and retirement bus of the multi-cycle datapath.
// With DATAFLOW_INSTRET_EN defined the bus also carries the 64-bit instret count.
interface fluxo_dados_multiciclo_if #(
    parameter int XLEN = 64
);
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic            retire_valid;
    logic [4:0]      retire_rd;
    logic [XLEN-1:0] retire_data;
    logic            illegal;
    logic [2:0]      flags;
`ifdef DATAFLOW_INSTRET_EN
    logic [63:0]     instret;

    modport master (
        output instr_valid, instr,
        input  instr_ready, pc, retire_valid, retire_rd, retire_data, illegal, flags, instret
    );
    modport slave (
        input  instr_valid, instr,
        output instr_ready, pc, retire_valid, retire_rd, retire_data, illegal, flags, instret
    );
`else
    modport master (
        output instr_valid, instr,
        input  instr_ready, pc, retire_valid, retire_rd, retire_data, illegal, flags
    );
    modport slave (
        input  instr_valid, instr,
        output instr_ready, pc, retire_valid, retire_rd, retire_data, illegal, flags
    );
`endif
endinterface

// File: rtl/fluxo_dados_multiciclo.sv
// Multi-cycle RISC-V datapath (ADD/SUB, ADDI, LUI, BRANCH, JAL): IDLE -> DECODE -> EXEC -> WB.
// Optional feature macro DATAFLOW_INSTRET_EN adds a 64-bit retired-instruction counter.
module fluxo_dados_multiciclo #(
    parameter int              XLEN     = 64,
    parameter int              NREG     = 32,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    fluxo_dados_multiciclo_if.slave bus
);
    localparam int          IW         = $clog2(NREG);
    localparam logic [31:0] IDX_OK     = (NREG >= 32) ? 32'hFFFF_FFFF : ((32'd1 << NREG) - 32'd1);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);
    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0]  OPC_LUI    = 7'b0110111;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] pc_q, npc_q, rs1_val_q, rs2_val_q, imm_q, retire_data_q;
    logic [XLEN-1:0] rf_q [NREG];
    logic [2:0]      flags_q;
    logic            retire_valid_q, illegal_q;
    logic [4:0]      retire_rd_q;
`ifdef DATAFLOW_INSTRET_EN
    logic [63:0]     instret_q;
`endif

    logic [6:0]      opcode_s;
    logic [4:0]      rd_s, rs1_s, rs2_s;
    logic [2:0]      funct3_s;
    logic            use_rd_s, use_rs1_s, use_rs2_s, bad_op_s, illegal_s;
    logic [XLEN-1:0] imm_s, rs1_rd_s, rs2_rd_s, opb_s, result_s, npc_s, ret_data_s;
    logic            igual_s, menor_s, mgu_s, taken_s, jump_s;
    logic [4:0]      ret_rd_s;

    function automatic logic idx_ok(input logic [4:0] idx);
        idx_ok = IDX_OK[idx];
    endfunction

    assign opcode_s = instr_q[6:0];
    assign rd_s     = instr_q[11:7];
    assign funct3_s = instr_q[14:12];
    assign rs1_s    = instr_q[19:15];
    assign rs2_s    = instr_q[24:20];

    // Opcode decode: which register fields are live and which immediate format applies.
    always_comb begin
        use_rd_s  = 1'b0;
        use_rs1_s = 1'b0;
        use_rs2_s = 1'b0;
        bad_op_s  = 1'b0;
        imm_s     = '0;
        case (opcode_s)
            OPC_OP: begin
                use_rd_s  = 1'b1;
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
            end
            OPC_OPIMM: begin
                use_rd_s  = 1'b1;
                use_rs1_s = 1'b1;
                imm_s     = XLEN'($signed(instr_q[31:20]));
            end
            OPC_LUI: begin
                use_rd_s = 1'b1;
                imm_s    = XLEN'($signed({instr_q[31:12], 12'b0}));
            end
            OPC_BRANCH: begin
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
                bad_op_s  = (funct3_s == 3'b010) || (funct3_s == 3'b011);
                imm_s     = XLEN'($signed({instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0}));
            end
            OPC_JAL: begin
                use_rd_s = 1'b1;
                imm_s    = XLEN'($signed({instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0}));
            end
            default: begin
                bad_op_s = 1'b1;
            end
        endcase
    end

    assign illegal_s = bad_op_s
                     | (use_rd_s  & ~idx_ok(rd_s))
                     | (use_rs1_s & ~idx_ok(rs1_s))
                     | (use_rs2_s & ~idx_ok(rs2_s));

    // Unused or out-of-range fields read as zero so the array index never leaves the file.
    assign rs1_rd_s = (use_rs1_s && rs1_s != 5'd0 && idx_ok(rs1_s)) ? rf_q[rs1_s[IW-1:0]] : '0;
    assign rs2_rd_s = (use_rs2_s && rs2_s != 5'd0 && idx_ok(rs2_s)) ? rf_q[rs2_s[IW-1:0]] : '0;

    assign opb_s   = use_rs2_s ? rs2_val_q : imm_q;
    assign igual_s = (rs1_val_q == opb_s);
    assign menor_s = ($signed(rs1_val_q) < $signed(opb_s));
    assign mgu_s   = (rs1_val_q >= opb_s);

    // ALU result and branch condition for the latched instruction.
    always_comb begin
        result_s = '0;
        taken_s  = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                if (instr_q[30]) result_s = rs1_val_q - opb_s;
                else             result_s = rs1_val_q + opb_s;
            end
            OPC_OPIMM: result_s = rs1_val_q + opb_s;
            OPC_LUI:   result_s = imm_q;
            OPC_JAL:   result_s = pc_q + PC_STEP;
            OPC_BRANCH: begin
                case (funct3_s)
                    3'b000:  taken_s = igual_s;
                    3'b001:  taken_s = ~igual_s;
                    3'b100:  taken_s = menor_s;
                    3'b101:  taken_s = ~menor_s;
                    3'b110:  taken_s = ~mgu_s;
                    3'b111:  taken_s = mgu_s;
                    default: taken_s = 1'b0;
                endcase
            end
            default: result_s = '0;
        endcase
    end

    assign jump_s     = ~illegal_s & (((opcode_s == OPC_BRANCH) & taken_s) | (opcode_s == OPC_JAL));
    assign npc_s      = pc_q + (jump_s ? imm_q : PC_STEP);
    assign ret_rd_s   = (~illegal_s & use_rd_s) ? rd_s : 5'd0;
    assign ret_data_s = (ret_rd_s != 5'd0) ? result_s : '0;

    // Sequencer next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.instr_valid) state_d = S_DECODE;
                else                 state_d = S_IDLE;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath state; retire outputs are loaded at the EXEC edge so they are valid exactly in WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            instr_q        <= 32'd0;
            pc_q           <= PC_RESET;
            npc_q          <= '0;
            rs1_val_q      <= '0;
            rs2_val_q      <= '0;
            imm_q          <= '0;
            flags_q        <= 3'd0;
            retire_valid_q <= 1'b0;
            retire_rd_q    <= 5'd0;
            retire_data_q  <= '0;
            illegal_q      <= 1'b0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
`ifdef DATAFLOW_INSTRET_EN
            instret_q      <= 64'd0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (bus.instr_valid) instr_q <= bus.instr;
                    else                 instr_q <= instr_q;
                end
                S_DECODE: begin
                    rs1_val_q <= rs1_rd_s;
                    rs2_val_q <= rs2_rd_s;
                    imm_q     <= imm_s;
                end
                S_EXEC: begin
                    retire_valid_q <= 1'b1;
                    illegal_q      <= illegal_s;
                    retire_rd_q    <= ret_rd_s;
                    retire_data_q  <= ret_data_s;
                    npc_q          <= npc_s;
                    if (!illegal_s && use_rs1_s) flags_q <= {mgu_s, menor_s, igual_s};
                    else                         flags_q <= flags_q;
                end
                S_WB: begin
                    retire_valid_q <= 1'b0;
                    illegal_q      <= 1'b0;
                    retire_rd_q    <= 5'd0;
                    retire_data_q  <= '0;
                    pc_q           <= npc_q;
                    if (retire_rd_q != 5'd0) rf_q[retire_rd_q[IW-1:0]] <= retire_data_q;
                    else                     rf_q[0] <= '0;
`ifdef DATAFLOW_INSTRET_EN
                    instret_q      <= instret_q + 64'd1;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.instr_ready  = (state_q == S_IDLE);
    assign bus.pc           = pc_q;
    assign bus.retire_valid = retire_valid_q;
    assign bus.retire_rd    = retire_rd_q;
    assign bus.retire_data  = retire_data_q;
    assign bus.illegal      = illegal_q;
    assign bus.flags        = flags_q;
`ifdef DATAFLOW_INSTRET_EN
    assign bus.instret      = instret_q;
`endif
endmodule

// File: tb/tb_fluxo_dados_multiciclo.sv
// Randomized bench for fluxo_dados_multiciclo against an architectural reference model.
module tb_fluxo_dados_multiciclo;
    localparam int NREG_TB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [63:0] m_reg [32];
    logic [63:0] m_pc;
    logic [2:0]  m_flags;
    logic [63:0] m_instret;
    logic [63:0] last_data;

    fluxo_dados_multiciclo_if #(.XLEN(64)) bus ();

    fluxo_dados_multiciclo #(.XLEN(64), .NREG(NREG_TB), .PC_RESET(64'd0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = 64'd0;
        m_pc      = 64'd0;
        m_flags   = 3'd0;
        m_instret = 64'd0;
    endtask

    // Architectural effect of one instruction, immediates rebuilt arithmetically.
    task automatic model_exec(input logic [31:0] ins, output logic ill,
                              output logic [4:0] rd_o, output logic [63:0] data_o);
        logic [6:0]  opc;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [63:0] a, b, val, imm_i, imm_b, imm_u, imm_j;
        logic        u_rd, u_rs1, u_rs2, eq, lt, geu, taken, jal;
        opc = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12]; rs1 = ins[19:15]; rs2 = ins[24:20];
        imm_i = 64'(ins[31:20]) - (ins[31] ? 64'd4096 : 64'd0);
        imm_b = 64'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}) - (ins[31] ? 64'd8192 : 64'd0);
        imm_u = 64'(ins[31:12]) * 64'd4096 - (ins[31] ? 64'h1_0000_0000 : 64'd0);
        imm_j = 64'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}) - (ins[31] ? 64'd2097152 : 64'd0);
        u_rd = 1'b0; u_rs1 = 1'b0; u_rs2 = 1'b0; ill = 1'b0; jal = 1'b0; taken = 1'b0;
        a = m_reg[rs1]; b = 64'd0; val = 64'd0;
        case (opc)
            7'h33: begin u_rd = 1'b1; u_rs1 = 1'b1; u_rs2 = 1'b1; b = m_reg[rs2];
                         val = ins[30] ? a - b : a + b; end
            7'h13: begin u_rd = 1'b1; u_rs1 = 1'b1; b = imm_i; val = a + b; end
            7'h37: begin u_rd = 1'b1; val = imm_u; end
            7'h63: begin u_rs1 = 1'b1; u_rs2 = 1'b1; b = m_reg[rs2];
                         ill = (f3 == 3'd2) || (f3 == 3'd3); end
            7'h6F: begin u_rd = 1'b1; jal = 1'b1; val = m_pc + 64'd4; end
            default: ill = 1'b1;
        endcase
        if ((u_rd && rd >= NREG_TB) || (u_rs1 && rs1 >= NREG_TB) || (u_rs2 && rs2 >= NREG_TB)) ill = 1'b1;
        eq = (a == b); lt = ($signed(a) < $signed(b)); geu = (a >= b);
        rd_o = 5'd0; data_o = 64'd0;
        if (ill) begin
            m_pc = m_pc + 64'd4;
        end else begin
            if (u_rs1) m_flags = {geu, lt, eq};
            if (opc == 7'h63) begin
                case (f3)
                    3'd0: taken = eq;
                    3'd1: taken = !eq;
                    3'd4: taken = lt;
                    3'd5: taken = !lt;
                    3'd6: taken = !geu;
                    default: taken = geu;
                endcase
            end
            if (u_rd && rd != 5'd0) begin
                m_reg[rd] = val; rd_o = rd; data_o = val;
            end
            m_pc = taken ? m_pc + imm_b : (jal ? m_pc + imm_j : m_pc + 64'd4);
        end
        m_instret = m_instret + 64'd1;
    endtask

    // Offers one instruction from IDLE and checks every cycle up to the return to IDLE.
    task automatic do_instr(input logic [31:0] ins);
        logic        e_ill;
        logic [4:0]  e_rd;
        logic [63:0] e_data;
        check_val("ready_idle", bus.instr_ready, 64'd1);
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'($urandom_range(0, 1));
        bus.instr       = $urandom;
        check_val("ready_busy", bus.instr_ready, 64'd0);
        check_val("retire_decode", bus.retire_valid, 64'd0);
        @(negedge clk);
        check_val("retire_exec", bus.retire_valid, 64'd0);
        @(negedge clk);
        model_exec(ins, e_ill, e_rd, e_data);
        check_val("retire_valid", bus.retire_valid, 64'd1);
        check_val("retire_rd", bus.retire_rd, 64'(e_rd));
        check_val("retire_data", bus.retire_data, e_data);
        check_val("illegal", bus.illegal, 64'(e_ill));
        last_data = bus.retire_data;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        check_val("retire_after_wb", bus.retire_valid, 64'd0);
        check_val("pc", bus.pc, m_pc);
        check_val("flags", bus.flags, 64'(m_flags));
`ifdef DATAFLOW_INSTRET_EN
        check_val("instret", bus.instret, m_instret);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_val("rst_ready", bus.instr_ready, 64'd1);
        check_val("rst_pc", bus.pc, 64'd0);
        check_val("rst_flags", bus.flags, 64'd0);
        check_val("rst_retire", bus.retire_valid, 64'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] r;
        rd  = 5'($urandom_range(0, 17));
        rs1 = 5'($urandom_range(0, 17));
        rs2 = 5'($urandom_range(0, 17));
        r   = $urandom;
        case ($urandom_range(0, 6))
            0:       rand_instr = {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, rs2, rs1, 3'b000, rd, 7'h33};
            1:       rand_instr = {r[11:0], rs1, 3'b000, rd, 7'h13};
            2:       rand_instr = {r[19:0], rd, 7'h37};
            3, 4:    rand_instr = {r[6:0], rs2, rs1, r[14:12], r[19:15], 7'h63};
            5:       rand_instr = {r[19:0], rd, 7'h6F};
            default: rand_instr = {r[24:0], (r[25] ? 7'h03 : 7'h23)};
        endcase
    endfunction

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr       = 32'd0;
        last_data       = 64'd0;
        model_reset();
        do_reset();

        do_instr(32'h0050_0093);                 // ADDI x1,x0,5
        check_val("plan_addi_data", last_data, 64'd5);
        check_val("plan_addi_pc", bus.pc, 64'd4);
        do_instr(32'hFFF0_0113);                 // ADDI x2,x0,-1
        do_instr(32'h4020_81B3);                 // SUB x3,x1,x2
        check_val("plan_sub_data", last_data, 64'd6);
        check_val("plan_sub_flags", bus.flags, 64'd0);
        do_instr(32'h0011_4463);                 // BLT x2,x1,+8
        check_val("plan_blt_pc", bus.pc, 64'd20);
        do_instr(32'h0011_6463);                 // BLTU x2,x1,+8
        check_val("plan_bltu_pc", bus.pc, 64'd24);
        do_instr(32'h0000_2083);                 // load: illegal
        check_val("plan_load_pc", bus.pc, 64'd28);

        do_reset();
        do_instr(32'hFFDF_F0EF);                 // JAL x1,-4 at pc 0
        check_val("plan_jal_link", last_data, 64'd4);
        check_val("plan_jal_pc", bus.pc, 64'hFFFF_FFFF_FFFF_FFFC);

        // Reset during EXEC of ADDI x5,x0,7 must abort it.
        do_reset();
        bus.instr_valid = 1'b1;
        bus.instr       = 32'h0070_0293;
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("abort_retire", bus.retire_valid, 64'd0);
        check_val("abort_pc", bus.pc, 64'd0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_val("abort_ready", bus.instr_ready, 64'd1);
        check_val("abort_retire2", bus.retire_valid, 64'd0);
        do_instr(32'h0002_8313);                 // ADDI x6,x5,0 reads x5
        check_val("abort_x5", last_data, 64'd0);

        for (int k = 0; k < 300; k++) do_instr(rand_instr());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
